// File: rtl/cwt_rf_pkg.sv
// ---------------------------------------------------------------------------
// cwt_rf_pkg
// Shared definitions for the CWT coefficient register-file readout path.
//   DEF_NUMBER_OF_REGISTERS : default number of register-file entries (64)
//   DEF_BITS                : default word width (16)
//   DEF_IDX_W               : default index width, clog2 of the entry count
//   rd_state_t              : readout FSM states {IDLE, STREAM}
// ---------------------------------------------------------------------------
package cwt_rf_pkg;
   localparam int DEF_NUMBER_OF_REGISTERS = 64;
   localparam int DEF_BITS                = 16;
   localparam int DEF_IDX_W               = $clog2(DEF_NUMBER_OF_REGISTERS);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;
endpackage

// File: rtl/reg_file_reader_if.sv
// ---------------------------------------------------------------------------
// reg_file_reader_if
// Valid/ready word stream leaving the register-file readout engine.
//   OutData  : current word
//   OutIdx   : register index of OutData
//   OutValid : OutData/OutIdx/OutLast are valid
//   OutLast  : current word is the final word of the readout
//   OutReady : downstream accepts the word when high
// master = producer (readout engine), slave = consumer.
// ---------------------------------------------------------------------------
interface reg_file_reader_if #(
   parameter int BITS  = cwt_rf_pkg::DEF_BITS,
   parameter int IDX_W = cwt_rf_pkg::DEF_IDX_W
);
   logic [BITS-1:0]  OutData;
   logic [IDX_W-1:0] OutIdx;
   logic             OutValid;
   logic             OutLast;
   logic             OutReady;

   modport master (
      output OutData,
      output OutIdx,
      output OutValid,
      output OutLast,
      input  OutReady
   );

   modport slave (
      input  OutData,
      input  OutIdx,
      input  OutValid,
      input  OutLast,
      output OutReady
   );
endinterface

// File: rtl/reg_word_mux.sv
// ---------------------------------------------------------------------------
// reg_word_mux
// Combinational NUMBER_OF_REGISTERS:1 word selector on the flattened
// register-file read bus.
//   reg_data : flattened bus, entry i at [i*BITS +: BITS]
//   sel      : entry to select
//   word     : selected entry
// ---------------------------------------------------------------------------
module reg_word_mux #(
   parameter int NUMBER_OF_REGISTERS = cwt_rf_pkg::DEF_NUMBER_OF_REGISTERS,
   parameter int BITS                = cwt_rf_pkg::DEF_BITS,
   parameter int IDX_W               = cwt_rf_pkg::DEF_IDX_W
) (
   input  logic [NUMBER_OF_REGISTERS*BITS-1:0] reg_data,
   input  logic [IDX_W-1:0]                    sel,
   output logic [BITS-1:0]                     word
);
   logic [BITS-1:0] words [NUMBER_OF_REGISTERS];

   generate
      for (genvar gi = 0; gi < NUMBER_OF_REGISTERS; gi++) begin : g_split
         assign words[gi] = reg_data[gi*BITS +: BITS];
      end
   endgenerate

   assign word = words[sel];
endmodule

// File: rtl/reg_file_reader.sv
// ---------------------------------------------------------------------------
// reg_file_reader
// Walks the register file's parallel read bus from index 0 upward and emits
// one word per accepted transfer on a valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   Start    : begin a readout (honoured in IDLE only)
//   Length   : words to read, sampled with Start, clamped to the entry count
//   Abort    : end an active readout without a Done pulse
//   RegData  : flattened register-file read bus
//   out_if   : output word stream (OutData/OutIdx/OutValid/OutLast/OutReady)
//   Busy     : high while streaming
//   Done     : one-cycle pulse on normal completion
// All outputs are registered; RegData feeds only the OutData D-input.
// ---------------------------------------------------------------------------
module reg_file_reader
   import cwt_rf_pkg::*;
#(
   parameter int NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
   parameter int BITS                = DEF_BITS,
   parameter int IDX_W               = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                Start,
   input  logic [IDX_W:0]                      Length,
   input  logic                                Abort,
   input  logic [NUMBER_OF_REGISTERS*BITS-1:0] RegData,
   output logic                                Busy,
   output logic                                Done,
   reg_file_reader_if.master                   out_if
);
   localparam logic [IDX_W:0]   NREG  = (IDX_W+1)'(NUMBER_OF_REGISTERS);
   localparam logic [IDX_W:0]   ONE_L = (IDX_W+1)'(1);
   localparam logic [IDX_W:0]   TWO_L = (IDX_W+1)'(2);
   localparam logic [IDX_W-1:0] ONE_I = IDX_W'(1);

   rd_state_t        state_q, state_d;
   logic [IDX_W:0]   len_q, len_d;
   logic [BITS-1:0]  data_q, data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [IDX_W:0]   len_clamped;
   logic [IDX_W-1:0] idx_inc;
   logic [IDX_W-1:0] mux_sel;
   logic [BITS-1:0]  mux_word;
   logic             is_final;
   logic             next_is_final;

   assign len_clamped   = (Length > NREG) ? NREG : Length;
   assign idx_inc       = idx_q + ONE_I;
   assign is_final      = ({1'b0, idx_q} == (len_q - ONE_L));
   assign next_is_final = (({1'b0, idx_q} + TWO_L) == len_q);

   // The mux always looks at the word that would be loaded next: entry 0
   // when a readout is about to start, idx+1 while streaming. On the final
   // word idx_inc may wrap, but nothing is loaded then.
   assign mux_sel = (state_q == STREAM) ? idx_inc : '0;

   reg_word_mux #(
      .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
      .BITS                (BITS),
      .IDX_W               (IDX_W)
   ) u_mux (
      .reg_data (RegData),
      .sel      (mux_sel),
      .word     (mux_word)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               if (len_clamped == '0) begin
                  done_d = 1'b1;
               end else begin
                  len_d   = len_clamped;
                  data_d  = mux_word;
                  idx_d   = '0;
                  last_d  = (len_clamped == ONE_L);
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            // Abort wins over a same-cycle transfer.
            if (Abort) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (valid_q && out_if.OutReady) begin
               if (is_final) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d  = idx_inc;
                  data_d = mux_word;
                  last_d = next_is_final;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_if.OutData  = data_q;
   assign out_if.OutIdx   = idx_q;
   assign out_if.OutValid = valid_q;
   assign out_if.OutLast  = last_q;
   assign Busy            = busy_q;
   assign Done            = done_q;
endmodule

// File: tb/tb_reg_file_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_file_reader
// Directed bench for reg_file_reader. Expected words are queued when a
// readout is started and popped on every accepted transfer.
// ---------------------------------------------------------------------------
module tb_reg_file_reader;
   localparam int NR = 64;
   localparam int BW = 16;
   localparam int IW = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [IW:0]       length;
   logic [NR*BW-1:0]  reg_data;
   logic              busy;
   logic              done;

   reg_file_reader_if #(.BITS(BW), .IDX_W(IW)) bus ();

   reg_file_reader #(
      .NUMBER_OF_REGISTERS (NR),
      .BITS                (BW),
      .IDX_W               (IW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .Start   (start),
      .Length  (length),
      .Abort   (abort),
      .RegData (reg_data),
      .Busy    (busy),
      .Done    (done),
      .out_if  (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   int            xfers  = 0;
   int            dones  = 0;
   logic          stall_prev = 1'b0;
   logic [BW-1:0] held_data;
   logic [IW-1:0] held_idx;
   int            x0;
   int            d0;
   exp_t          etmp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_words(input int count, input int len);
      exp_t e;
      for (int i = 0; i < count; i++) begin
         e.data = reg_data[i*BW +: BW];
         e.idx  = IW'(i);
         e.last = (i == len - 1);
         sb.push_back(e);
      end
   endtask

   // One clock cycle: at the falling edge drive the inputs for the next rising
   // edge, then judge the outputs currently presented.
   task automatic cyc(input logic rdy, input logic st, input logic ab, input logic rs);
      exp_t e;
      @(negedge clk);
      bus.OutReady = rdy;
      start        = st;
      abort        = ab;
      rst          = rs;
      if (stall_prev) begin
         chk("stall_data", 32'(bus.OutData), 32'(held_data));
         chk("stall_idx", 32'(bus.OutIdx), 32'(held_idx));
      end
      stall_prev = bus.OutValid && !rdy && !ab && !rs;
      held_data  = bus.OutData;
      held_idx   = bus.OutIdx;
      if (bus.OutValid && rdy && !ab && !rs) begin
         xfers++;
         chk("sb_avail", 32'(sb.size() != 0), 32'd1);
         e = (sb.size() != 0) ? sb.pop_front() : '0;
         chk("xfer_data", 32'(bus.OutData), 32'(e.data));
         chk("xfer_idx", 32'(bus.OutIdx), 32'(e.idx));
         chk("xfer_last", 32'(bus.OutLast), 32'(e.last));
         $display("xfer idx %0d data %h last %b", bus.OutIdx, bus.OutData, bus.OutLast);
      end
      if (done) dones++;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      while (!got && n < budget) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         n++;
         got = done;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      length       = '0;
      bus.OutReady = 1'b0;
      for (int i = 0; i < NR; i++) reg_data[i*BW +: BW] = 16'h1000 + 16'(i);

      // Reset state
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_data", 32'(bus.OutData), 32'd0);
      chk("rst_idx", 32'(bus.OutIdx), 32'd0);
      chk("rst_valid", 32'(bus.OutValid), 32'd0);
      chk("rst_last", 32'(bus.OutLast), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Full 64-word readout, OutReady held high
      length = 7'd64;
      push_words(64, 64);
      x0 = xfers; d0 = dones;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (64) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("full_xfers", 32'(xfers - x0), 32'd64);
      chk("full_no_early_done", 32'(dones - d0), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("full_done", 32'(done), 32'd1);
      chk("full_valid_low", 32'(bus.OutValid), 32'd0);
      chk("full_busy_low", 32'(busy), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("full_done_pulse", 32'(done), 32'd0);

      // Backpressure: OutReady 1,0,0,1,1,0,1
      length = 7'd4;
      push_words(4, 4);
      x0 = xfers;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_xfers", 32'(xfers - x0), 32'd4);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_done", 32'(done), 32'd1);

      // Zero length
      length = 7'd0;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_valid", 32'(bus.OutValid), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("len0_done_pulse", 32'(done), 32'd0);
      chk("len0_valid2", 32'(bus.OutValid), 32'd0);
      chk("len0_busy", 32'(busy), 32'd0);

      // Length above entry count is clamped
      length = 7'd100;
      push_words(64, 64);
      x0 = xfers;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      run_until_done(80, "len100");
      chk("len100_xfers", 32'(xfers - x0), 32'd64);

      // Single word
      length = 7'd1;
      push_words(1, 1);
      x0 = xfers;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("len1_xfers", 32'(xfers - x0), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("len1_done", 32'(done), 32'd1);

      // Live update of entry 5
      chk("sb_drained", 32'(sb.size()), 32'd0);
      reg_data[5*BW +: BW] = 16'hAAAA;
      length = 7'd8;
      push_words(8, 8);
      etmp = sb[5];
      etmp.data = 16'h5555;
      sb[5] = etmp;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      reg_data[5*BW +: BW] = 16'h5555;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("live_first_write", 32'(bus.OutData), 32'h5555);
      chk("live_idx", 32'(bus.OutIdx), 32'd5);
      reg_data[5*BW +: BW] = 16'h1234;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("live_held", 32'(bus.OutData), 32'h5555);
      run_until_done(20, "live");
      reg_data[5*BW +: BW] = 16'h1005;

      // Abort with OutReady on word 10 of 64
      length = 7'd64;
      push_words(10, 64);
      d0 = dones;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("abort_at_idx", 32'(bus.OutIdx), 32'd10);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("abort_valid", 32'(bus.OutValid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_last", 32'(bus.OutLast), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("abort_no_done", 32'(dones - d0), 32'd0);
      chk("abort_sb_empty", 32'(sb.size()), 32'd0);
      length = 7'd3;
      push_words(3, 3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_idx0", 32'(bus.OutIdx), 32'd0);
      chk("restart_valid", 32'(bus.OutValid), 32'd1);
      run_until_done(10, "restart");

      // Reset at word 20 of a second readout
      length = 7'd64;
      push_words(20, 64);
      d0 = dones;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("mrst_at_idx", 32'(bus.OutIdx), 32'd20);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("mrst_data", 32'(bus.OutData), 32'd0);
      chk("mrst_idx", 32'(bus.OutIdx), 32'd0);
      chk("mrst_valid", 32'(bus.OutValid), 32'd0);
      chk("mrst_last", 32'(bus.OutLast), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("mrst_no_done", 32'(dones - d0), 32'd0);
      chk("mrst_sb_empty", 32'(sb.size()), 32'd0);

      // Start while busy is ignored; Start during Done begins a new readout
      length = 7'd4;
      push_words(4, 4);
      x0 = xfers;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      length = 7'd10;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("ign_xfers", 32'(xfers - x0), 32'd4);
      length = 7'd2;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("ign_done", 32'(done), 32'd1);
      push_words(2, 2);
      x0 = xfers;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_first_xfer", 32'(xfers - x0), 32'd1);
      run_until_done(10, "b2b");
      chk("b2b_xfers", 32'(xfers - x0), 32'd2);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
